// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter between NREQ requesters.
// Packets (bytes up to i_req_last) keep the grant locked so they go out contiguously.
module uart_tx_arbiter #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned IDW        = 2,
  parameter int unsigned GAP_CLOCKS = 868,
  parameter int unsigned GAP_BITS   = 10,
  parameter int unsigned START_TMO  = 16,
  parameter int unsigned LOCK_TMO   = 4095
) (
  input  logic              clk,
  input  logic              i_reset_n,
  input  logic [NREQ-1:0]   i_req_valid,
  input  logic [8*NREQ-1:0] i_req_data,
  input  logic [NREQ-1:0]   i_req_last,
  output logic [NREQ-1:0]   o_req_ready,
  input  logic              i_tx_busy,
  output logic              o_tx_start,
  output logic [7:0]        o_tx_data,
  output logic [IDW-1:0]    o_owner,
  output logic              o_locked,
  output logic              o_err_tmo
);

  localparam int unsigned TMO_MAX = (LOCK_TMO > START_TMO) ? LOCK_TMO : START_TMO;
  localparam int unsigned TW      = $clog2(TMO_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, ACCEPT, START, WAIT_BUSY, WAIT_DONE, GAP, HOLD
  } state_t;

  state_t              state, state_nx;
  logic [IDW-1:0]      owner, owner_nx;
  logic [IDW-1:0]      rr, rr_nx;
  logic                locked, locked_nx;
  logic [7:0]          tx_data, tx_data_nx;
  logic [GAP_BITS-1:0] gap_cnt, gap_nx;
  logic [TW-1:0]       tmo_cnt, tmo_nx;

  logic [IDW-1:0]      winner;
  logic [IDW-1:0]      owner_inc;
  logic                valid_own;
  logic                last_own;
  logic [7:0]          data_own;

  assign valid_own = i_req_valid[owner];
  assign last_own  = i_req_last[owner];
  assign data_own  = i_req_data[{owner, 3'b000} +: 8];
  assign owner_inc = (owner == IDW'(NREQ - 1)) ? '0 : owner + IDW'(1);

  // First valid requester at or above rr, wrapping past NREQ-1.
  always_comb begin
    int unsigned idx;
    logic [IDW-1:0] cand;
    logic found;
    winner = rr;
    found  = 1'b0;
    idx    = 0;
    cand   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = i + rr;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IDW'(idx);
      if (!found && i_req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= IDLE;
      owner   <= '0;
      rr      <= '0;
      locked  <= 1'b0;
      tx_data <= '0;
      gap_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nx;
      owner   <= owner_nx;
      rr      <= rr_nx;
      locked  <= locked_nx;
      tx_data <= tx_data_nx;
      gap_cnt <= gap_nx;
      tmo_cnt <= tmo_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    owner_nx    = owner;
    rr_nx       = rr;
    locked_nx   = locked;
    tx_data_nx  = tx_data;
    gap_nx      = gap_cnt;
    tmo_nx      = tmo_cnt;
    o_req_ready = '0;
    o_tx_start  = 1'b0;
    o_err_tmo   = 1'b0;
    unique case (state)
      IDLE: begin
        // A frame left over from before reset must finish before a new grant.
        if (|i_req_valid && !i_tx_busy) begin
          owner_nx = winner;
          state_nx = ACCEPT;
        end
      end
      ACCEPT: begin
        o_req_ready[owner] = 1'b1;
        if (valid_own) begin
          tx_data_nx = data_own;
          locked_nx  = !last_own;
          if (last_own) rr_nx = owner_inc;
          state_nx = START;
        end else begin
          locked_nx = 1'b0;
          state_nx  = IDLE;
        end
      end
      START: begin
        o_tx_start = 1'b1;
        tmo_nx     = '0;
        state_nx   = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (i_tx_busy) begin
          state_nx = WAIT_DONE;
        end else if (tmo_cnt == TW'(START_TMO - 1)) begin
          o_err_tmo = 1'b1;
          gap_nx    = GAP_BITS'(GAP_CLOCKS - 1);
          state_nx  = GAP;
        end else begin
          tmo_nx = tmo_cnt + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!i_tx_busy) begin
          gap_nx   = GAP_BITS'(GAP_CLOCKS - 1);
          state_nx = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          if (locked && valid_own) begin
            state_nx = ACCEPT;
          end else if (locked) begin
            tmo_nx   = '0;
            state_nx = HOLD;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          gap_nx = gap_cnt - GAP_BITS'(1);
        end
      end
      HOLD: begin
        // Owner went quiet mid-packet; give up the lock after LOCK_TMO clocks.
        if (valid_own) begin
          state_nx = ACCEPT;
        end else if (tmo_cnt == TW'(LOCK_TMO - 1)) begin
          locked_nx = 1'b0;
          rr_nx     = owner_inc;
          state_nx  = IDLE;
        end else begin
          tmo_nx = tmo_cnt + TW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign o_tx_data = tx_data;
  assign o_owner   = owner;
  assign o_locked  = locked;

endmodule
